// File: rtl/axi4_lite_slave_write_buf_pkg.sv
// Shared types for the AXI4-Lite write buffer: FSM state encoding and B-channel response codes.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HAVE_AW = 3'd1,
        HAVE_W  = 3'd2,
        MEM     = 3'd3,
        RESP    = 3'd4
    } t_wr_state;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_slave_write_buf.sv
// AXI4-Lite single-outstanding write slave that forwards one beat to a simple memory port.
// Optional memory-wait timeout enabled by defining AXI4_LITE_SLAVE_WRITE_BUF_TIMEOUT_EN.
import axi4_lite_pkg::*;

module axi4_lite_slave_write_buf #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic                          AW_VALID,
    input  logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
    input  logic [2:0]                    AW_PROT,
    output logic                          AW_READY,
    input  logic                          W_VALID,
    input  logic [AXI_DATA_WIDTH-1:0]     W_DATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
    output logic                          W_READY,
    input  logic                          B_READY,
    output logic                          B_VALID,
    output logic [1:0]                    B_RESP,
    output logic [AXI_ADDR_WIDTH-1:0]     o_addr,
    output logic [AXI_DATA_WIDTH-1:0]     o_data,
    output logic [AXI_DATA_WIDTH/8-1:0]   o_strb,
    output logic [2:0]                    o_prot,
    output logic                          o_write_en,
    input  logic                          i_write_done,
    input  logic                          i_write_err
);

    localparam int SW       = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = (AXI_DATA_WIDTH == 64) ? 3 : 2;

    t_wr_state                 state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]             strb_q, strb_d;
    logic [2:0]                prot_q, prot_d;
    logic [1:0]                resp_q, resp_d;
    logic                      wen_q, wen_d;
    logic                      bvalid_q, bvalid_d;
    logic                      aw_ready_s, w_ready_s;
    logic                      aw_hs_s, w_hs_s, have_aw_s, have_w_s;
    logic                      timeout_s;

`ifdef AXI4_LITE_SLAVE_WRITE_BUF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wait counter: zero outside MEM so it starts from zero on every MEM entry.
    always_comb begin
        cnt_d = {CNT_W{1'b0}};
        if (state_q == MEM) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_s = (state_q == MEM) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Ready decode, capture of handshaked fields and next-state selection.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        strb_d     = strb_q;
        prot_d     = prot_q;
        resp_d     = resp_q;
        aw_ready_s = 1'b0;
        w_ready_s  = 1'b0;
        case (state_q)
            IDLE:    begin aw_ready_s = 1'b1; w_ready_s = 1'b1; end
            HAVE_AW: w_ready_s  = 1'b1;
            HAVE_W:  aw_ready_s = 1'b1;
            default: begin aw_ready_s = 1'b0; w_ready_s = 1'b0; end
        endcase
        aw_hs_s   = AW_VALID && aw_ready_s;
        w_hs_s    = W_VALID && w_ready_s;
        have_aw_s = aw_hs_s || (state_q == HAVE_AW);
        have_w_s  = w_hs_s || (state_q == HAVE_W);
        if (aw_hs_s) begin
            addr_d = AW_ADDR;
            prot_d = AW_PROT;
        end else begin
            addr_d = addr_q;
        end
        if (w_hs_s) begin
            data_d = W_DATA;
            strb_d = W_STRB;
        end else begin
            data_d = data_q;
        end
        case (state_q)
            IDLE, HAVE_AW, HAVE_W: begin
                // Misalignment outranks an empty strobe: both skip the memory access.
                if (have_aw_s && have_w_s) begin
                    if (addr_d[ADDR_LSB-1:0] != {ADDR_LSB{1'b0}}) begin
                        state_d = RESP;
                        resp_d  = RESP_SLVERR;
                    end else if (strb_d == {SW{1'b0}}) begin
                        state_d = RESP;
                        resp_d  = RESP_OKAY;
                    end else begin
                        state_d = MEM;
                    end
                end else if (have_aw_s) begin
                    state_d = HAVE_AW;
                end else if (have_w_s) begin
                    state_d = HAVE_W;
                end else begin
                    state_d = state_q;
                end
            end
            MEM: begin
                if (i_write_done) begin
                    state_d = RESP;
                    resp_d  = i_write_err ? RESP_SLVERR : RESP_OKAY;
                end else if (timeout_s) begin
                    state_d = RESP;
                    resp_d  = RESP_SLVERR;
                end else begin
                    state_d = state_q;
                end
            end
            RESP: begin
                if (B_READY) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = IDLE;
        endcase
        wen_d    = (state_d == MEM);
        bvalid_d = (state_d == RESP);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= IDLE;
            addr_q   <= {AXI_ADDR_WIDTH{1'b0}};
            data_q   <= {AXI_DATA_WIDTH{1'b0}};
            strb_q   <= {SW{1'b0}};
            prot_q   <= 3'b000;
            resp_q   <= 2'b00;
            wen_q    <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
            prot_q   <= prot_d;
            resp_q   <= resp_d;
            wen_q    <= wen_d;
            bvalid_q <= bvalid_d;
        end
    end

    assign AW_READY   = aw_ready_s;
    assign W_READY    = w_ready_s;
    assign B_VALID    = bvalid_q;
    assign B_RESP     = resp_q;
    assign o_addr     = addr_q;
    assign o_data     = data_q;
    assign o_strb     = strb_q;
    assign o_prot     = prot_q;
    assign o_write_en = wen_q;

endmodule

// File: tb/tb_axi4_lite_slave_write_buf.sv
// Self-checking bench for axi4_lite_slave_write_buf: vector table plus scoreboard of B responses.
module tb_axi4_lite_slave_write_buf;

    logic        clk = 1'b0;
    logic        arstn;
    logic        AW_VALID, AW_READY;
    logic [63:0] AW_ADDR;
    logic [2:0]  AW_PROT;
    logic        W_VALID, W_READY;
    logic [31:0] W_DATA;
    logic [3:0]  W_STRB;
    logic        B_READY, B_VALID;
    logic [1:0]  B_RESP;
    logic [63:0] o_addr;
    logic [31:0] o_data;
    logic [3:0]  o_strb;
    logic [2:0]  o_prot;
    logic        o_write_en, i_write_done, i_write_err;

    axi4_lite_slave_write_buf #(
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .arstn(arstn),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_STRB(W_STRB), .W_READY(W_READY),
        .B_READY(B_READY), .B_VALID(B_VALID), .B_RESP(B_RESP),
        .o_addr(o_addr), .o_data(o_data), .o_strb(o_strb), .o_prot(o_prot),
        .o_write_en(o_write_en), .i_write_done(i_write_done), .i_write_err(i_write_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          mem_cyc;
        logic        err;
        int          b_dly;
        int          exp_wen;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t        vecs[7];
    logic [1:0]  sb_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs, w_hs;
        int c = 0;
        int n = 0;
        logic [1:0] r;
        sb_q.push_back(v.exp_resp);
        while (!(aw_done && w_done) && c < 50) begin
            AW_VALID = !aw_done && (c >= v.aw_dly);
            AW_ADDR  = v.addr;
            AW_PROT  = 3'b010;
            W_VALID  = !w_done && (c >= v.w_dly);
            W_DATA   = v.data;
            W_STRB   = v.strb;
            if (aw_done) chk("aw_ready_in_have_aw", AW_READY, 64'd0);
            if (w_done)  chk("w_ready_in_have_w", W_READY, 64'd0);
            aw_hs = AW_VALID && AW_READY;
            w_hs  = W_VALID && W_READY;
            @(posedge clk); #1;
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            c++;
        end
        AW_VALID = 1'b0;
        W_VALID  = 1'b0;
        chk("handshake_bound", {63'd0, aw_done && w_done}, 64'd1);
        chk("wen_latency", {63'd0, o_write_en}, (v.exp_wen != 0) ? 64'd1 : 64'd0);
        while (o_write_en && n < 100) begin
            n++;
            chk("o_addr", o_addr, v.addr);
            chk("o_data", {32'd0, o_data}, {32'd0, v.data});
            chk("o_strb", {60'd0, o_strb}, {60'd0, v.strb});
            chk("o_prot", {61'd0, o_prot}, 64'd2);
            i_write_done = (n == v.mem_cyc);
            i_write_err  = v.err;
            @(posedge clk); #1;
        end
        i_write_done = 1'b0;
        i_write_err  = 1'b0;
        chk("wen_cycles", 64'(n), 64'(v.exp_wen));
        for (int k = 0; k < v.b_dly; k++) begin
            chk("b_valid_hold", {63'd0, B_VALID}, 64'd1);
            chk("b_resp_hold", {62'd0, B_RESP}, {62'd0, v.exp_resp});
            chk("aw_ready_in_resp", {63'd0, AW_READY}, 64'd0);
            chk("w_ready_in_resp", {63'd0, W_READY}, 64'd0);
            @(posedge clk); #1;
        end
        chk("b_valid", {63'd0, B_VALID}, 64'd1);
        B_READY = 1'b1;
        if (B_VALID) begin
            r = sb_q.pop_front();
            chk("b_resp", {62'd0, B_RESP}, {62'd0, r});
        end
        @(posedge clk); #1;
        B_READY = 1'b0;
        chk("b_valid_after_hs", {63'd0, B_VALID}, 64'd0);
        chk("aw_ready_after_hs", {63'd0, AW_READY}, 64'd1);
        chk("w_ready_after_hs", {63'd0, W_READY}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv;
        //          addr          data           strb  awd wd mem err bd wen resp
        vecs[0] = '{64'h40,  32'hDEADBEEF, 4'hF, 0, 3, 2, 1'b0, 0, 2, 2'b00};
        vecs[1] = '{64'h80,  32'h12345678, 4'h3, 2, 0, 1, 1'b0, 1, 1, 2'b00};
        vecs[2] = '{64'h100, 32'hA5A5A5A5, 4'hF, 0, 0, 3, 1'b0, 0, 3, 2'b00};
        vecs[3] = '{64'h42,  32'h11111111, 4'hF, 0, 0, 1, 1'b0, 2, 0, 2'b10};
        vecs[4] = '{64'h44,  32'h22222222, 4'h0, 0, 1, 1, 1'b0, 0, 0, 2'b00};
        vecs[5] = '{64'h43,  32'h33333333, 4'h0, 1, 0, 1, 1'b0, 0, 0, 2'b10};
        vecs[6] = '{64'h48,  32'hCAFEF00D, 4'hF, 1, 0, 1, 1'b1, 5, 1, 2'b10};

        arstn = 1'b0;
        AW_VALID = 1'b0; AW_ADDR = 64'd0; AW_PROT = 3'd0;
        W_VALID = 1'b0; W_DATA = 32'd0; W_STRB = 4'd0;
        B_READY = 1'b0; i_write_done = 1'b0; i_write_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wen", {63'd0, o_write_en}, 64'd0);
        chk("rst_bvalid", {63'd0, B_VALID}, 64'd0);
        chk("rst_bresp", {62'd0, B_RESP}, 64'd0);
        chk("rst_addr", o_addr, 64'd0);
        arstn = 1'b1;
        @(posedge clk); #1;
        chk("rel_aw_ready", {63'd0, AW_READY}, 64'd1);
        chk("rel_w_ready", {63'd0, W_READY}, 64'd1);

        // Stray completion outside MEM must not move the FSM.
        i_write_done = 1'b1;
        @(posedge clk); #1;
        i_write_done = 1'b0;
        chk("done_ignored_bvalid", {63'd0, B_VALID}, 64'd0);
        chk("done_ignored_ready", {63'd0, AW_READY}, 64'd1);
        chk("done_ignored_wen", {63'd0, o_write_en}, 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i]);
        end

`ifdef AXI4_LITE_SLAVE_WRITE_BUF_TIMEOUT_EN
        tv = '{64'h300, 32'h0BADF00D, 4'hF, 0, 0, 0, 1'b0, 0, 8, 2'b10};
        run_txn(tv);
        tv = '{64'h304, 32'h600DF00D, 4'hF, 0, 0, 8, 1'b0, 0, 8, 2'b00};
        run_txn(tv);
`else
        tv = '{64'h300, 32'h0BADF00D, 4'hF, 0, 0, 12, 1'b0, 0, 12, 2'b00};
        run_txn(tv);
`endif

        // Reset while in MEM: abort, outputs cleared asynchronously, no response.
        AW_VALID = 1'b1; AW_ADDR = 64'h200; AW_PROT = 3'b001;
        W_VALID = 1'b1; W_DATA = 32'h55AA55AA; W_STRB = 4'hF;
        @(posedge clk); #1;
        AW_VALID = 1'b0; W_VALID = 1'b0;
        chk("abort_wen_before", {63'd0, o_write_en}, 64'd1);
        @(posedge clk); #2;
        arstn = 1'b0;
        #1;
        chk("abort_wen", {63'd0, o_write_en}, 64'd0);
        chk("abort_bvalid", {63'd0, B_VALID}, 64'd0);
        chk("abort_bresp", {62'd0, B_RESP}, 64'd0);
        chk("abort_addr", o_addr, 64'd0);
        chk("abort_data", {32'd0, o_data}, 64'd0);
        chk("abort_strb", {60'd0, o_strb}, 64'd0);
        chk("abort_prot", {61'd0, o_prot}, 64'd0);
        @(posedge clk); #1;
        arstn = 1'b1;
        @(posedge clk); #1;
        chk("abort_rel_aw_ready", {63'd0, AW_READY}, 64'd1);
        chk("abort_rel_w_ready", {63'd0, W_READY}, 64'd1);
        chk("abort_no_b", {63'd0, B_VALID}, 64'd0);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
